// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Gaussian convolution block.
//   DATA_W_DEF : default pixel width
//   K_*_SH     : kernel weights as shift amounts (weight = 1 << K_*_SH)
//   ROUND/SHIFT: normalisation of the 16-weight kernel sum
//   row_sum_w / total_w : derived widths that cannot overflow
package conv_pkg;

  localparam int DATA_W_DEF = 8;

  // 1-D kernel [1 2 1]. The 2-D kernel is its outer product, so the centre
  // weight 4 comes from applying the edge shift once per dimension.
  localparam int K_SIDE_SH = 0;
  localparam int K_EDGE_SH = 1;

  // Kernel weights add up to 16: round half-up, then divide by 16.
  localparam int ROUND = 8;
  localparam int SHIFT = 4;

  // A [1 2 1] row sum is at most 4*max, which needs 2 extra bits.
  localparam int ROW_GROW = 2;
  // The full 3x3 sum plus ROUND is at most 16*max+8, which needs 4 extra bits.
  localparam int TOT_GROW = 4;

  function automatic int row_sum_w(input int dw);
    return dw + ROW_GROW;
  endfunction

  function automatic int total_w(input int dw);
    return dw + TOT_GROW;
  endfunction

endpackage

// File: rtl/conv_window3x3.sv
// 3x3 pixel window built from incoming 3-pixel columns, with column tracking.
//   clk, rstb  : clock, asynchronous active-low reset
//   advance    : pipeline may move this cycle
//   accept     : a new column is taken this cycle (implies advance)
//   rows       : incoming column, [DATA_W-1:0] top, then middle, then bottom
//   win        : 9 pixels, pixel (r,c) at [(3*r+c)*DATA_W +: DATA_W], c=0 oldest
//   win_valid  : window holds three columns of the current line
//   win_eol    : window was completed by the last column of a line
module conv_window3x3
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                advance,
  input  logic                accept,
  input  logic [3*DATA_W-1:0] rows,
  output logic [9*DATA_W-1:0] win,
  output logic                win_valid,
  output logic                win_eol
);

  localparam int COL_W = (IMG_WIDTH > 4) ? $clog2(IMG_WIDTH) : 2;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);

  logic [3*DATA_W-1:0] left_r;
  logic [3*DATA_W-1:0] mid_r;
  logic [3*DATA_W-1:0] right_r;
  logic [COL_W-1:0]    col_r;
  logic                col_last_s;

  assign col_last_s = (col_r == COL_LAST);

  // Column shift register, column counter and window qualifiers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      left_r    <= '0;
      mid_r     <= '0;
      right_r   <= '0;
      col_r     <= '0;
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
    end else if (accept) begin
      left_r    <= mid_r;
      mid_r     <= right_r;
      right_r   <= rows;
      col_r     <= col_last_s ? '0 : col_r + COL_W'(1);
      // The first two columns of a line leave the window straddling lines.
      win_valid <= (col_r >= COL_FIRST);
      win_eol   <= col_last_s;
    end else if (advance) begin
      // No new column: push a bubble, keep pixels and column count.
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign win[(3*r+0)*DATA_W +: DATA_W] = left_r[r*DATA_W +: DATA_W];
    assign win[(3*r+1)*DATA_W +: DATA_W] = mid_r[r*DATA_W +: DATA_W];
    assign win[(3*r+2)*DATA_W +: DATA_W] = right_r[r*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/gauss_conv3x3.sv
// 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16) over a column stream.
// Pipeline: window -> row sums -> total+round -> output register.
//   clk, rstb : clock, asynchronous active-low reset
//   i_valid   : input column valid
//   i_rows    : column of 3 pixels, top in the LSBs
//   o_ready   : input column accepted when i_valid is also 1
//   o_valid   : o_pix holds a filtered pixel
//   o_pix     : filtered pixel
//   o_eol     : o_pix is the last output of its line
//   i_ready   : downstream takes o_pix
module gauss_conv3x3
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                i_valid,
  input  logic [3*DATA_W-1:0] i_rows,
  output logic                o_ready,
  output logic                o_valid,
  output logic [DATA_W-1:0]   o_pix,
  output logic                o_eol,
  input  logic                i_ready
);

  localparam int RS_W  = row_sum_w(DATA_W);
  localparam int TOT_W = total_w(DATA_W);

  logic                advance_s;
  logic                accept_s;
  logic [9*DATA_W-1:0] win_s;
  logic                win_valid_s;
  logic                win_eol_s;
  logic [DATA_W-1:0]   pix_s [9];

  logic [RS_W-1:0]     rs_top_r;
  logic [RS_W-1:0]     rs_mid_r;
  logic [RS_W-1:0]     rs_bot_r;
  logic                s1_valid_r;
  logic                s1_eol_r;
  logic [TOT_W-1:0]    tot_r;
  logic                s2_valid_r;
  logic                s2_eol_r;

  // The whole pipeline moves together whenever the output slot is free
  // or being drained, which keeps ordering and gives 1 pixel/clock.
  assign advance_s = ~o_valid | i_ready;
  assign accept_s  = i_valid & advance_s;
  assign o_ready   = advance_s;

  conv_window3x3 #(
    .IMG_WIDTH (IMG_WIDTH),
    .DATA_W    (DATA_W)
  ) u_window (
    .clk       (clk),
    .rstb      (rstb),
    .advance   (advance_s),
    .accept    (accept_s),
    .rows      (i_rows),
    .win       (win_s),
    .win_valid (win_valid_s),
    .win_eol   (win_eol_s)
  );

  for (genvar i = 0; i < 9; i++) begin : g_pix
    assign pix_s[i] = win_s[i*DATA_W +: DATA_W];
  end

  // One [1 2 1] row using shifts and adds.
  function automatic logic [RS_W-1:0] row_121(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
    return (RS_W'(a) << K_SIDE_SH) + (RS_W'(b) << K_EDGE_SH) + (RS_W'(c) << K_SIDE_SH);
  endfunction

  // Row sums, weighted total with rounding, and the output register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rs_top_r   <= '0;
      rs_mid_r   <= '0;
      rs_bot_r   <= '0;
      s1_valid_r <= 1'b0;
      s1_eol_r   <= 1'b0;
      tot_r      <= '0;
      s2_valid_r <= 1'b0;
      s2_eol_r   <= 1'b0;
      o_pix      <= '0;
      o_valid    <= 1'b0;
      o_eol      <= 1'b0;
    end else if (advance_s) begin
      rs_top_r   <= row_121(pix_s[0], pix_s[1], pix_s[2]);
      rs_mid_r   <= row_121(pix_s[3], pix_s[4], pix_s[5]);
      rs_bot_r   <= row_121(pix_s[6], pix_s[7], pix_s[8]);
      s1_valid_r <= win_valid_s;
      s1_eol_r   <= win_valid_s & win_eol_s;

      tot_r      <= (TOT_W'(rs_top_r) << K_SIDE_SH) + (TOT_W'(rs_mid_r) << K_EDGE_SH)
                  + (TOT_W'(rs_bot_r) << K_SIDE_SH) + TOT_W'(ROUND);
      s2_valid_r <= s1_valid_r;
      s2_eol_r   <= s1_eol_r;

      // Max total+ROUND is 16*max+8, so the shifted value always fits.
      o_pix      <= DATA_W'(tot_r >> SHIFT);
      o_valid    <= s2_valid_r;
      o_eol      <= s2_eol_r;
    end
  end

endmodule

// File: tb/tb_gauss_conv3x3.sv
module tb_gauss_conv3x3;

  localparam int IMG_W = 8;
  localparam int DW    = 8;

  logic          clk;
  logic          rstb;
  logic          i_valid;
  logic [3*DW-1:0] i_rows;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_pix;
  logic          o_eol;
  logic          i_ready;

  int checks;
  int errors;
  int lost_beats;

  logic [DW-1:0] q_pix [$];
  logic          q_eol [$];

  gauss_conv3x3 #(
    .IMG_WIDTH (IMG_W),
    .DATA_W    (DW)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .i_valid (i_valid),
    .i_rows  (i_rows),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_pix   (o_pix),
    .o_eol   (o_eol),
    .i_ready (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake (values are stable between negedge and posedge).
  always @(negedge clk) begin
    if (rstb && o_valid && i_ready) begin
      q_pix.push_back(o_pix);
      q_eol.push_back(o_eol);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Column c of a test pattern, packed {bottom, middle, top}.
  function automatic logic [3*DW-1:0] col_rows(input int kind, input int c);
    logic [DW-1:0] g;
    g = DW'(16 * c);
    case (kind)
      0:       return {3{8'd100}};
      1:       return {3{8'd255}};
      2:       return {g, g, g};
      3:       return (c == 3) ? 24'h00FF00 : 24'h000000;
      4:       return (c == 3) ? 24'h0000FF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  // Present one column until it is accepted (bounded).
  task automatic send_col(input logic [3*DW-1:0] rows);
    bit done;
    bit acc_now;
    done    = 1'b0;
    i_valid = 1'b1;
    i_rows  = rows;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      acc_now = o_ready;
      @(posedge clk);
      #1;
      if (acc_now) done = 1'b1;
    end
    i_valid = 1'b0;
    if (!done) lost_beats++;
  endtask

  // Drive a full line, optionally with one idle cycle after every beat, then drain.
  task automatic run_line(input int kind, input bit gapped);
    for (int c = 0; c < IMG_W; c++) begin
      send_col(col_rows(kind, c));
      if (gapped) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstb    = 1'b0;
    i_valid = 1'b0;
    i_rows  = '0;
    i_ready = 1'b1;
    #2;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %0b expected 0", o_valid); end
    checks++; if (o_pix !== 8'd0) begin errors++; $display("FAIL reset_o_pix got %0d expected 0", o_pix); end
    checks++; if (o_eol !== 1'b0) begin errors++; $display("FAIL reset_o_eol got %0b expected 0", o_eol); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got %0b expected 1", o_ready); end
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  // Flat field with exact cycle-by-cycle latency: beat e accepted at edge e.
  task automatic test_flat;
    bit exp_v;
    bit exp_e;
    q_pix.delete(); q_eol.delete();
    for (int e = 0; e < 13; e++) begin
      i_valid = (e < IMG_W);
      i_rows  = {3{8'd100}};
      @(posedge clk);
      #1;
      exp_v = (e >= 5 && e <= 10);
      exp_e = (e == 10);
      checks++; if (o_valid !== exp_v) begin errors++; $display("FAIL flat_valid edge %0d got %0b expected %0b", e, o_valid, exp_v); end
      checks++; if (o_eol !== exp_e) begin errors++; $display("FAIL flat_eol edge %0d got %0b expected %0b", e, o_eol, exp_e); end
      if (exp_v) begin
        checks++; if (o_pix !== 8'd100) begin errors++; $display("FAIL flat_pix edge %0d got %0d expected 100", e, o_pix); end
      end
    end
    i_valid = 1'b0;
    checks++; if (q_pix.size() !== 6) begin errors++; $display("FAIL flat_count got %0d expected 6", q_pix.size()); end
  endtask

  task automatic test_impulse;
    int exp_tab [2][6];
    exp_tab[0] = '{0, 32, 64, 32, 0, 0};
    exp_tab[1] = '{0, 16, 32, 16, 0, 0};
    for (int k = 0; k < 2; k++) begin
      q_pix.delete(); q_eol.delete();
      run_line(3 + k, 1'b0);
      checks++; if (q_pix.size() !== 6) begin errors++; $display("FAIL impulse%0d_count got %0d expected 6", k, q_pix.size()); end
      for (int j = 0; j < q_pix.size() && j < 6; j++) begin
        checks++; if (q_pix[j] !== DW'(exp_tab[k][j])) begin errors++; $display("FAIL impulse%0d_pix idx %0d got %0d expected %0d", k, j, q_pix[j], exp_tab[k][j]); end
        checks++; if (q_eol[j] !== (j == 5)) begin errors++; $display("FAIL impulse%0d_eol idx %0d got %0b expected %0b", k, j, q_eol[j], (j == 5)); end
      end
    end
  endtask

  task automatic test_max;
    q_pix.delete(); q_eol.delete();
    run_line(1, 1'b0);
    checks++; if (q_pix.size() !== 6) begin errors++; $display("FAIL max_count got %0d expected 6", q_pix.size()); end
    for (int j = 0; j < q_pix.size() && j < 6; j++) begin
      checks++; if (q_pix[j] !== 8'd255) begin errors++; $display("FAIL max_pix idx %0d got %0d expected 255", j, q_pix[j]); end
      checks++; if (q_eol[j] !== (j == 5)) begin errors++; $display("FAIL max_eol idx %0d got %0b expected %0b", j, q_eol[j], (j == 5)); end
    end
  endtask

  // Gradient line (outputs 16,32,...,96) with a 5-cycle downstream stall.
  task automatic test_backpressure;
    q_pix.delete(); q_eol.delete();
    lost_beats = 0;
    fork
      run_line(2, 1'b0);
      begin
        repeat (7) @(posedge clk);
        #1;
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_o_ready cyc %0d got %0b expected 0", k, o_ready); end
          checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_o_valid cyc %0d got %0b expected 1", k, o_valid); end
          checks++; if (o_pix !== 8'd32) begin errors++; $display("FAIL bp_hold_pix cyc %0d got %0d expected 32", k, o_pix); end
          checks++; if (o_eol !== 1'b0) begin errors++; $display("FAIL bp_hold_eol cyc %0d got %0b expected 0", k, o_eol); end
          @(posedge clk);
        end
        #1;
        i_ready = 1'b1;
      end
    join
    checks++; if (lost_beats !== 0) begin errors++; $display("FAIL bp_beats_timeout got %0d expected 0", lost_beats); end
    checks++; if (q_pix.size() !== 6) begin errors++; $display("FAIL bp_count got %0d expected 6", q_pix.size()); end
    for (int j = 0; j < q_pix.size() && j < 6; j++) begin
      checks++; if (q_pix[j] !== DW'(16 * (j + 1))) begin errors++; $display("FAIL bp_pix idx %0d got %0d expected %0d", j, q_pix[j], 16 * (j + 1)); end
      checks++; if (q_eol[j] !== (j == 5)) begin errors++; $display("FAIL bp_eol idx %0d got %0b expected %0b", j, q_eol[j], (j == 5)); end
    end
  endtask

  task automatic test_gapped;
    q_pix.delete(); q_eol.delete();
    lost_beats = 0;
    run_line(2, 1'b1);
    checks++; if (lost_beats !== 0) begin errors++; $display("FAIL gap_beats_timeout got %0d expected 0", lost_beats); end
    checks++; if (q_pix.size() !== 6) begin errors++; $display("FAIL gap_count got %0d expected 6", q_pix.size()); end
    for (int j = 0; j < q_pix.size() && j < 6; j++) begin
      checks++; if (q_pix[j] !== DW'(16 * (j + 1))) begin errors++; $display("FAIL gap_pix idx %0d got %0d expected %0d", j, q_pix[j], 16 * (j + 1)); end
      checks++; if (q_eol[j] !== (j == 5)) begin errors++; $display("FAIL gap_eol idx %0d got %0b expected %0b", j, q_eol[j], (j == 5)); end
    end
  endtask

  task automatic test_reset_midline;
    q_pix.delete(); q_eol.delete();
    // Columns 0..5 of a gradient line; the col-2 window reaches the output after col 5.
    for (int c = 0; c < 6; c++) send_col(col_rows(2, c));
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b expected 1", o_valid); end
    checks++; if (o_pix !== 8'd16) begin errors++; $display("FAIL rst_pre_pix got %0d expected 16", o_pix); end
    rstb = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b expected 0", o_valid); end
    checks++; if (o_pix !== 8'd0) begin errors++; $display("FAIL rst_mid_pix got %0d expected 0", o_pix); end
    checks++; if (o_eol !== 1'b0) begin errors++; $display("FAIL rst_mid_eol got %0b expected 0", o_eol); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b expected 1", o_ready); end
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    checks++; if (q_pix.size() !== 0) begin errors++; $display("FAIL rst_pre_outputs got %0d expected 0", q_pix.size()); end
    run_line(2, 1'b0);
    checks++; if (q_pix.size() !== 6) begin errors++; $display("FAIL rst_post_count got %0d expected 6", q_pix.size()); end
    for (int j = 0; j < q_pix.size() && j < 6; j++) begin
      checks++; if (q_pix[j] !== DW'(16 * (j + 1))) begin errors++; $display("FAIL rst_post_pix idx %0d got %0d expected %0d", j, q_pix[j], 16 * (j + 1)); end
      checks++; if (q_eol[j] !== (j == 5)) begin errors++; $display("FAIL rst_post_eol idx %0d got %0b expected %0b", j, q_eol[j], (j == 5)); end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    lost_beats = 0;
    test_reset();
    test_flat();
    repeat (4) @(posedge clk);
    #1;
    test_impulse();
    test_max();
    test_backpressure();
    test_gapped();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss_conv3x3.md
GAUSS_CONV3X3 -- requirements
Module: gauss_conv3x3

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512: pixels per image line, legal range 3..4096.
REQ-002 SHALL have parameter DATA_W, default 8: bits per pixel.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all logic on rising edge.
REQ-004 SHALL have port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, 1 bit: upstream line-buffer column is valid.
REQ-006 SHALL have port i_rows, input, 3*DATA_W bits: one column of three vertically aligned pixels; [DATA_W-1:0] top, middle next, bottom MSBs.
REQ-007 SHALL have port o_ready, output, 1 bit: block accepts i_rows this cycle.
REQ-008 SHALL have port o_valid, output, 1 bit: o_pix holds a filtered pixel.
REQ-009 SHALL have port o_pix, output, DATA_W bits: filtered pixel.
REQ-010 SHALL have port o_eol, output, 1 bit: qualifies the last output pixel of a line.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts o_pix.

Function
REQ-012 SHALL accept an input beat when i_valid and o_ready are both 1.
REQ-013 SHALL drive o_ready = advance, where advance = (not o_valid) or i_ready.
REQ-014 SHALL, when advance is 0, hold every pipeline register, including o_pix, o_valid and o_eol.
REQ-015 SHALL, on each accepted beat, shift the 3x3 window left one column and load i_rows into the rightmost column.
REQ-016 SHALL keep a column counter col, 0..IMG_WIDTH-1, incremented on each accepted beat and wrapping to 0 after IMG_WIDTH-1.
REQ-017 SHALL mark a window as valid only when the accepted beat has col >= 2, giving IMG_WIDTH-2 outputs per line.
REQ-018 SHALL flag the window from the beat with col = IMG_WIDTH-1 as end-of-line; that flag propagates to o_eol alongside its pixel.
REQ-019 SHALL use the kernel [1 2 1; 2 4 2; 1 2 1], implemented with shifts and adds only, no multipliers.
REQ-020 SHALL compute row sums of DATA_W+2 bits and a total of DATA_W+4 bits, so no intermediate overflows.
REQ-021 SHALL compute o_pix = (total + 8) >> 4, which needs no saturation because the maximum result is 2^DATA_W-1.
REQ-022 SHALL have pipeline stages window -> row sums -> total+round -> output register.
REQ-023 SHALL give a latency of 3 advancing cycles: a beat accepted at edge N with a valid window sets o_valid after edge N+3.
REQ-024 SHALL sustain throughput of 1 pixel/clock when i_ready is held at 1.
REQ-025 SHALL leave state unchanged on cycles with i_valid = 0 and advance = 1, other than draining bubbles through the pipeline.
REQ-026 SHALL, when a line boundary occurs mid-pipeline, keep outputs from the previous line ordered and unaffected, and mark window entries for col 0 and 1 of the new line invalid.
REQ-027 SHALL present each o_valid pixel for exactly one i_ready handshake, with no duplication or loss under any backpressure pattern.

Reset
REQ-028 SHALL, while rstb = 0, asynchronously clear o_valid, o_eol, o_pix, col, all pipeline valid/eol flags and all window and sum registers to 0.
REQ-029 SHALL set o_ready to 1 during reset because o_valid is 0.
REQ-030 SHALL, after release mid-line, treat the next accepted beat as col 0, with no output derived from pre-reset data.

Structure
REQ-031 SHALL place DATA_W default, kernel weights, ROUND = 8, SHIFT = 4 and the derived sum widths in shared package conv_pkg.
REQ-032 SHALL implement the 3x3 shift-register window with col tracking in sub-module conv_window3x3, which outputs 9 pixels plus win_valid and win_eol.
REQ-033 SHALL be 120-400 lines of RTL.

Verification
REQ-034 SHALL cover flat field: IMG_WIDTH=8, all pixels 100, i_ready=1 -> 6 outputs per line, all 100, o_eol on the 6th, first o_valid 3 cycles after col-2 accept.
REQ-035 SHALL cover impulse: centre 255 with all others 0 -> centre output 64 and 4-neighbour outputs 32 ((510+8)>>4); diagonal outputs 16 ((255+8)>>4).
REQ-036 SHALL cover maximum: all 255 -> every output 255 with no wrap (total 4080, +8 -> 255).
REQ-037 SHALL cover backpressure: i_ready=0 for 5 cycles mid-line with i_valid=1 -> o_ready=0, o_pix/o_eol stable, no beats lost, output sequence identical to the unstalled run.
REQ-038 SHALL cover gapped input: i_valid toggling every other cycle -> same output values and o_eol position as continuous input.
REQ-039 SHALL cover reset mid-line: rstb pulsed low at col 5 of an 8-wide line -> outputs clear immediately; the next line produces exactly 6 outputs starting from the 3rd accepted beat.
